regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised integer register file for the pipelined core: NREAD async read ports, one sync write
//  port, hardwired-zero x0, optional write-to-read bypass. Integrated pending-write scoreboard
//  (busy bit per register) flags RAW hazards to decode and blocks WAW re-issue. Sits between
//  decode (addresses and issue) and writeback (wr_*).
// PARAMETERS
//  XLEN     32              data width
//  NREGS    32              number of architectural registers (power of 2, >=2)
//  NREAD    2               number of read ports (1..4)
//  AW       $clog2(NREGS)   register address width (derived; do not override)
//  BYPASS   1               1: same-cycle write data forwarded to matching reads; 0: old value read
// PORTS
//  clk         in   1            clock, all state updates on posedge
//  rst         in   1            synchronous, active-high reset
//  rd_addr     in   NREAD*AW     read addresses, port i at [i*AW +: AW]
//  rd_data     out  NREAD*XLEN   read data, port i at [i*XLEN +: XLEN]
//  rd_busy     out  NREAD        port i source has a pending write (RAW hazard)
//  wr_en       in   1            writeback strobe
//  wr_addr     in   AW           writeback destination
//  wr_data     in   XLEN         writeback data
//  issue_en    in   1            decode issues an instruction writing issue_rd
//  issue_rd    in   AW           destination of issued instruction
//  issue_ready out  1            issue accepted this cycle if issue_en
//  busy_count  out  AW+1         number of registers with pending writes
// BEHAVIOUR
//  - Reset: rst high at posedge -> all NREGS regs = 0, all busy bits = 0, busy_count = 0.
//    rst has priority over wr_en and issue_en in the same cycle. While rst high: rd_busy = 0,
//    issue_ready = 0, bypass disabled.
//  - Reads: combinational, zero latency. rd_addr == 0 -> rd_data = 0, rd_busy = 0 always.
//    BYPASS=1 and wr_en and wr_addr == rd_addr != 0 -> rd_data = wr_data, rd_busy = 0.
//    Otherwise rd_data = regs[rd_addr], rd_busy = busy[rd_addr].
//  - Write: wr_en at posedge -> regs[wr_addr] <= wr_data, busy[wr_addr] <= 0. wr_addr == 0 ignored.
//    1-cycle latency; BYPASS=0 read in same cycle returns the old value.
//  - Issue: issue_ready = !rst && (issue_rd == 0 || !busy[issue_rd] ||
//    (wr_en && wr_addr == issue_rd)). issue_en && issue_ready -> busy[issue_rd] <= 1
//    (x0 never set). issue_en && !issue_ready -> no state change; decode retries.
//  - Same-register write and issue in one cycle: issue wins, busy stays 1, data updated.
//  - busy_count: registered; +1 on accepted issue to nonzero reg not already busy, -1 on write
//    clearing a set busy bit; both same reg same cycle -> unchanged. Saturation unreachable
//    (max NREGS-1); assertion on over/underflow.
//  - Write to non-busy register (e.g. CSR path, debug) legal: data written, count unchanged.
//  - regs[0] physically absent or forced to 0; never observable nonzero.
// STRUCTURE
//  - regfile_pkg: XLEN/NREGS defaults, reg_addr_t, xlen_t typedefs, REG_ZERO constant.
//  - Sub-module regfile_scoreboard: busy vector, issue_ready, rd_busy masking, busy_count.
//    Top level holds data array, read muxes, bypass, generate loop over NREAD.
// TESTING
//  - Reset: write 0xDEADBEEF to x5, assert rst 1 cycle -> rd x5 = 0, busy_count = 0, rd_busy = 0.
//  - x0: wr_en, addr 0, data 0x1234; issue_rd 0 -> rd x0 = 0, busy_count stays 0, issue_ready 1.
//  - Bypass: wr x7 = 0xA5A5A5A5 with rd_addr0 = 7 same cycle -> rd_data0 = 0xA5A5A5A5 (BYPASS=1),
//    old value (BYPASS=0); next cycle both = 0xA5A5A5A5.
//  - Scoreboard: issue x3 -> next cycle rd_busy for x3 = 1, busy_count = 1; re-issue x3 ->
//    issue_ready 0; wr x3 = 9 -> rd_busy 0, count 0, rd = 9.
//  - Simultaneous: x3 busy, wr x3 + issue x3 same cycle -> issue_ready 1, busy stays 1, count 1,
//    rd x3 = new data.
//  - NREAD=4, NREGS=16: random issue/write/read vs reference model, 10k cycles, no mismatch.

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// Shared types and defaults for the multiport integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_multiport_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  // Architectural zero register; reads as 0 and never carries a pending write.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback side bundle of the register file: read ports, writeback and issue.
// Latency: reads combinational; writeback and issue take effect at the next clk edge.
// Backpressure: issue_ready low means decode must hold issue_rd and retry.
interface regfile_multiport_if
  import regfile_multiport_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  issue_en;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic [AW:0]           busy_count;

  // Pipeline side: decode drives addresses/issue, writeback drives wr_*.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rd_data, rd_busy, issue_ready, busy_count
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rd_data, rd_busy, issue_ready, busy_count
  );

endinterface

// File: rtl/regfile_multiport_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, RAW flags per read port, WAW issue gate.
// Latency: rd_busy/issue_ready combinational; busy bits and busy_count update on the next edge.
// Backpressure: issue_ready drops while the destination already has a write in flight.
module regfile_multiport_scoreboard #(
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] rd_addr,
  input  logic [NREAD-1:0]    byp_hit,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREAD-1:0]    rd_busy,
  output logic                issue_ready,
  output logic [AW:0]         busy_count
);

  // Count can never exceed every register except x0 being busy.
  localparam logic [AW:0] CNT_MAX = (AW+1)'(NREGS - 1);

  logic [NREGS-1:0] busy;
  logic             issue_acc;
  logic             wr_clr;
  logic             inc;
  logic             dec;

  // Issue gating and the count delta; a write to the issued register frees it in the same cycle.
  always_comb begin
    issue_ready = !rst && (issue_rd == '0 || !busy[issue_rd] ||
                           (wr_en && wr_addr == issue_rd));
    issue_acc   = issue_en && issue_ready && issue_rd != '0;
    wr_clr      = wr_en && wr_addr != '0;
    inc         = issue_acc && !busy[issue_rd];
    // A clear that is immediately re-set by the same-cycle issue is not a release.
    dec         = wr_clr && busy[wr_addr] && !(issue_acc && issue_rd == wr_addr);
  end

  // Per-port RAW flag; x0, forwarded reads and reset never report a hazard.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_busy[i] = !rst && rd_addr[i*AW +: AW] != '0 && !byp_hit[i] &&
                   busy[rd_addr[i*AW +: AW]];
    end
  end

  // Busy vector and population count; issue is applied after the write clear so issue wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_clr) busy[wr_addr] <= 1'b0;
      if (issue_acc) busy[issue_rd] <= 1'b1;
      if (inc && !dec) busy_count <= busy_count + 1'b1;
      else if (dec && !inc) busy_count <= busy_count - 1'b1;
    end
  end

  a_cnt_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && busy_count == CNT_MAX));
  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && busy_count == '0));

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NREAD async read ports, one sync write port, x0 hardwired, optional bypass.
// Latency: reads 0 cycles, writes visible 1 cycle later (same cycle when forwarded).
// Backpressure: issue_ready from the scoreboard stalls decode on a WAW to a busy register.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = NREAD_DEF,
  parameter bit BYPASS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_multiport_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs   [NREGS];
  logic [XLEN-1:0] rd_val [NREAD];
  logic [NREAD-1:0] byp_hit;

  // Data array; entry 0 is cleared on reset and never written, so x0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (bus.wr_en && bus.wr_addr != '0) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a          = bus.rd_addr[i*AW +: AW];
    // Forward the writeback value when it targets this port's source (never during reset).
    assign byp_hit[i] = BYPASS && !rst && bus.wr_en && bus.wr_addr == a && a != '0;
    assign rd_val[i]  = (a == '0) ? '0 : (byp_hit[i] ? bus.wr_data : regs[a]);
  end

  // Pack per-port read values onto the flat read bus.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NREAD; i++) bus.rd_data[i*XLEN +: XLEN] = rd_val[i];
  end

  regfile_multiport_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (bus.rd_addr),
    .byp_hit     (byp_hit),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .issue_en    (bus.issue_en),
    .issue_rd    (bus.issue_rd),
    .rd_busy     (bus.rd_busy),
    .issue_ready (bus.issue_ready),
    .busy_count  (bus.busy_count)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios on 32x2 (bypass on/off) plus random 16x4 vs a model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: issue_ready is checked against the model every cycle.
module tb_regfile_multiport;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus ();
  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_nb ();
  regfile_multiport_if #(.XLEN(32), .NREGS(16), .NREAD(4)) bus4 ();

  // The no-bypass instance sees exactly the same stimulus as the bypass one.
  assign bus_nb.rd_addr  = bus.rd_addr;
  assign bus_nb.wr_en    = bus.wr_en;
  assign bus_nb.wr_addr  = bus.wr_addr;
  assign bus_nb.wr_data  = bus.wr_data;
  assign bus_nb.issue_en = bus.issue_en;
  assign bus_nb.issue_rd = bus.issue_rd;

  regfile_multiport #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  regfile_multiport #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb));
  regfile_multiport #(.XLEN(32), .NREGS(16), .NREAD(4), .BYPASS(1'b1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   b;
    logic         rdy;
    logic [4:0]   cnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic idle();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.issue_en = 1'b0;
    bus.issue_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // rst held from time 0; outputs during reset
    repeat (2) @(posedge clk);
    #1;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd5;
    #1;
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL rst_issue_ready got=%b exp=0", bus.issue_ready); end
    total++; if (bus.busy_count !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.busy_count); end
    rst = 1'b0; idle();
    // x5 = DEADBEEF, x6 made busy
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd6;
    step(); idle();
    bus.rd_addr[4:0] = 5'd5; bus.rd_addr[9:5] = 5'd6;
    #1;
    total++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_rst_x5 got=%h exp=deadbeef", bus.rd_data[31:0]); end
    total++; if (bus.rd_busy[1] !== 1'b1) begin bad++; $display("FAIL pre_rst_busy_x6 got=%b exp=1", bus.rd_busy[1]); end
    total++; if (bus.busy_count !== 6'd1) begin bad++; $display("FAIL pre_rst_count got=%0d exp=1", bus.busy_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL post_rst_x5 got=%h exp=0", bus.rd_data[31:0]); end
    total++; if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL post_rst_busy got=%b exp=00", bus.rd_busy); end
    total++; if (bus.busy_count !== 6'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", bus.busy_count); end
  endtask

  task automatic test_x0();
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready got=%b exp=1", bus.issue_ready); end
    total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL x0_nobypass got=%h exp=0", bus.rd_data[31:0]); end
    step(); idle();
    #1;
    total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", bus.rd_data[31:0]); end
    total++; if (bus.busy_count !== 6'd0) begin bad++; $display("FAIL x0_count got=%0d exp=0", bus.busy_count); end
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL x0_busy got=%b exp=0", bus.rd_busy[0]); end
  endtask

  task automatic test_bypass();
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5A5A5A5;
    bus.rd_addr[4:0] = 5'd7;
    #1;
    total++; if (bus.rd_data[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_on got=%h exp=a5a5a5a5", bus.rd_data[31:0]); end
    total++; if (bus_nb.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL byp_off_old got=%h exp=0", bus_nb.rd_data[31:0]); end
    step();
    bus.wr_en = 1'b0;
    #1;
    total++; if (bus.rd_data[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_on_next got=%h exp=a5a5a5a5", bus.rd_data[31:0]); end
    total++; if (bus_nb.rd_data[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_off_next got=%h exp=a5a5a5a5", bus_nb.rd_data[31:0]); end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL sb_issue_ready got=%b exp=1", bus.issue_ready); end
    step();
    bus.issue_en = 1'b0; bus.rd_addr[4:0] = 5'd3;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_raw got=%b exp=1", bus.rd_busy[0]); end
    total++; if (bus.busy_count !== 6'd1) begin bad++; $display("FAIL sb_count1 got=%0d exp=1", bus.busy_count); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    #1;
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL sb_waw_block got=%b exp=0", bus.issue_ready); end
    step();
    bus.issue_en = 1'b0;
    #1;
    total++; if (bus.busy_count !== 6'd1) begin bad++; $display("FAIL sb_retry_count got=%0d exp=1", bus.busy_count); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'd9;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_fwd_busy got=%b exp=0", bus.rd_busy[0]); end
    total++; if (bus_nb.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_nofwd_busy got=%b exp=1", bus_nb.rd_busy[0]); end
    step();
    bus.wr_en = 1'b0;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", bus.rd_busy[0]); end
    total++; if (bus.busy_count !== 6'd0) begin bad++; $display("FAIL sb_count0 got=%0d exp=0", bus.busy_count); end
    total++; if (bus.rd_data[31:0] !== 32'd9) begin bad++; $display("FAIL sb_data got=%h exp=9", bus.rd_data[31:0]); end
  endtask

  task automatic test_simultaneous();
    idle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    step();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h55;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL sim_issue_ready got=%b exp=1", bus.issue_ready); end
    step(); idle();
    bus.rd_addr[4:0] = 5'd3;
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sim_busy got=%b exp=1", bus.rd_busy[0]); end
    total++; if (bus.busy_count !== 6'd1) begin bad++; $display("FAIL sim_count got=%0d exp=1", bus.busy_count); end
    total++; if (bus.rd_data[31:0] !== 32'h55) begin bad++; $display("FAIL sim_data got=%h exp=55", bus.rd_data[31:0]); end
    // two more in flight, then a non-busy write that must not move the count
    bus.issue_en = 1'b1; bus.issue_rd = 5'd10;
    step();
    bus.issue_rd = 5'd11;
    step(); idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'h77;
    step(); idle();
    #1;
    total++; if (bus.busy_count !== 6'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", bus.busy_count); end
  endtask

  task automatic test_random();
    logic [31:0] mregs [16];
    logic [15:0] mbusy;
    int          mcount;
    logic [3:0]  wa, ird, a;
    logic [31:0] wd;
    logic        we, ie;
    exp_t        e, g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 16; r++) mregs[r] = '0;
    mbusy  = '0;
    mcount = 0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      we  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      wa  = 4'($urandom);
      ird = 4'($urandom);
      wd  = $urandom;
      bus4.wr_en = we; bus4.wr_addr = wa; bus4.wr_data = wd;
      bus4.issue_en = ie; bus4.issue_rd = ird;
      e.d = '0; e.b = '0;
      for (int p = 0; p < 4; p++) begin
        a = 4'($urandom);
        bus4.rd_addr[p*4 +: 4] = a;
        if (a == 4'd0) begin
          e.d[p*32 +: 32] = '0; e.b[p] = 1'b0;
        end else if (!rst && we && wa == a) begin
          e.d[p*32 +: 32] = wd; e.b[p] = 1'b0;
        end else begin
          e.d[p*32 +: 32] = mregs[a]; e.b[p] = !rst && mbusy[a];
        end
      end
      e.rdy = !rst && (ird == 4'd0 || !mbusy[ird] || (we && wa == ird));
      e.cnt = 5'(mcount);
      exp_q.push_back(e);
      #1;
      g = exp_q.pop_front();
      total++; if (bus4.rd_data !== g.d) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, bus4.rd_data, g.d); end
      total++; if (bus4.rd_busy !== g.b) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, bus4.rd_busy, g.b); end
      total++; if (bus4.issue_ready !== g.rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus4.issue_ready, g.rdy); end
      total++; if (bus4.busy_count !== g.cnt) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus4.busy_count, g.cnt); end
      // next state of the reference model
      if (rst) begin
        for (int r = 0; r < 16; r++) mregs[r] = '0;
        mbusy = '0;
      end else begin
        if (we && wa != 4'd0) begin mregs[wa] = wd; mbusy[wa] = 1'b0; end
        if (ie && g.rdy && ird != 4'd0) mbusy[ird] = 1'b1;
      end
      mcount = $countones(mbusy);
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    bus4.rd_addr = '0; bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0;
    bus4.issue_en = 1'b0; bus4.issue_rd = '0;
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
